// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register pending (busy) scoreboard for tracking in-flight results.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  input  logic              Iss,
  input  logic [ADDR_W-1:0] IssAddr,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   BusyCnt
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int CNT_W     = ADDR_W + 1;
  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regMem [DEPTH];
  logic [DEPTH-1:0]  busyReg;
  logic [DEPTH-1:0]  busyNext;
  logic [CNT_W-1:0]  busyCntReg;
  logic [CNT_W-1:0]  busyCntNext;
  logic              wrEff;
  logic              issEff;

  function automatic logic isHardZero(input logic [ADDR_W-1:0] addr);
    return HARD_ZERO && (addr == '0);
  endfunction

  assign wrEff  = WrEn && !isHardZero(Awr);
  assign issEff = Iss && !isHardZero(IssAddr);

  // Data storage; register 0 is never written when hardwired, reads mask it anyway.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regMem[i] <= '0;
      end
    end else if (wrEff) begin
      regMem[Awr] <= Din;
    end
  end

  // Issue is applied after completion, so a same-address issue+write leaves the flag set.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : genBusy
      if (HARD_ZERO && (gi == 0)) begin : genZero
        assign busyNext[gi] = 1'b0;
      end else begin : genFlag
        assign busyNext[gi] = (issEff && (IssAddr == ADDR_W'(gi))) ||
                              (busyReg[gi] && !(WrEn && (Awr == ADDR_W'(gi))));
      end
    end
  endgenerate

  // Count tracks only real flag transitions, so it equals the popcount and cannot wrap.
  always_comb begin
    busyCntNext = busyCntReg;
    if (issEff && !busyReg[IssAddr]) begin
      busyCntNext = busyCntNext + CNT_W'(1);
    end
    if (WrEn && busyReg[Awr] && !(issEff && (IssAddr == Awr))) begin
      busyCntNext = busyCntNext - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busyReg    <= '0;
      busyCntReg <= '0;
    end else begin
      busyReg    <= busyNext;
      busyCntReg <= busyCntNext;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : genRead
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = (gi == 0) ? Ard1 : Ard2;

      // A write landing on the read address forwards its data and retires the pending flag.
      always_comb begin
        data = regMem[addr];
        busy = busyReg[addr];
        if (isHardZero(addr)) begin
          data = '0;
          busy = 1'b0;
        end else if (WrEn && (Awr == addr)) begin
          data = Din;
          busy = 1'b0;
        end
      end
    end
  endgenerate

  assign Dout1   = genRead[0].data;
  assign Dout2   = genRead[1].data;
  assign Busy1   = genRead[0].busy;
  assign Busy2   = genRead[1].busy;
  assign BusyCnt = busyCntReg;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven from one stimulus stream,
// checked every cycle against an array/popcount model plus literal expectations.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [4:0]  ard1 = '0, ard2 = '0, awr = '0, issAddr = '0;
  logic [31:0] din = '0;
  logic        wrEn = 1'b0, iss = 1'b0;

  logic [31:0] dout1A, dout2A, dout1B, dout2B;
  logic [15:0] dout1C, dout2C;
  logic        busy1A, busy2A, busy1B, busy2B, busy1C, busy2C;
  logic [5:0]  busyCntA, busyCntB;
  logic [3:0]  busyCntC;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dutA (
    .Clk(clk), .Rst(rst), .Ard1(ard1), .Ard2(ard2), .Dout1(dout1A), .Dout2(dout2A),
    .Awr(awr), .Din(din), .WrEn(wrEn), .Iss(iss), .IssAddr(issAddr),
    .Busy1(busy1A), .Busy2(busy2A), .BusyCnt(busyCntA));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutB (
    .Clk(clk), .Rst(rst), .Ard1(ard1), .Ard2(ard2), .Dout1(dout1B), .Dout2(dout2B),
    .Awr(awr), .Din(din), .WrEn(wrEn), .Iss(iss), .IssAddr(issAddr),
    .Busy1(busy1B), .Busy2(busy2B), .BusyCnt(busyCntB));

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dutC (
    .Clk(clk), .Rst(rst), .Ard1(ard1[2:0]), .Ard2(ard2[2:0]), .Dout1(dout1C), .Dout2(dout2C),
    .Awr(awr[2:0]), .Din(din[15:0]), .WrEn(wrEn), .Iss(iss), .IssAddr(issAddr[2:0]),
    .Busy1(busy1C), .Busy2(busy2C), .BusyCnt(busyCntC));

  int assertCount = 0;
  int failCount   = 0;
  bit checking    = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } litT;
  litT litQ[$];

  // Model: instance k has its own address/data width and zero-register setting.
  logic [31:0] mMem  [3][32];
  bit          mBusy [3][32];

  function automatic int cfgAw(int k);
    return (k == 2) ? 3 : 5;
  endfunction
  function automatic logic [31:0] amask(int k);
    return (32'd1 << cfgAw(k)) - 32'd1;
  endfunction
  function automatic logic [31:0] dmask(int k);
    return (k == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
  endfunction
  function automatic bit prot(int k, logic [31:0] a);
    return (k != 1) && (a == 32'd0);
  endfunction

  function automatic logic [31:0] expData(int k, logic [31:0] a);
    if (prot(k, a)) return 32'd0;
    if (wrEn && ((awr & amask(k)) == a)) return din & dmask(k);
    return mMem[k][a];
  endfunction
  function automatic logic [31:0] expBusy(int k, logic [31:0] a);
    if (prot(k, a)) return 32'd0;
    if (wrEn && ((awr & amask(k)) == a)) return 32'd0;
    return {31'd0, mBusy[k][a]};
  endfunction
  function automatic logic [31:0] expCount(int k);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mBusy[k][i]);
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          mMem[k][i]  <= 32'd0;
          mBusy[k][i] <= 1'b0;
        end
      end else begin
        if (wrEn) begin
          if (!prot(k, awr & amask(k))) mMem[k][awr & amask(k)] <= din & dmask(k);
          mBusy[k][awr & amask(k)] <= 1'b0;
        end
        if (iss && !prot(k, issAddr & amask(k))) mBusy[k][issAddr & amask(k)] <= 1'b1;
      end
    end
  end

  task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic checkInst(int k);
    logic [31:0] d1, d2, b1, b2, cnt;
    case (k)
      0: begin d1 = dout1A; d2 = dout2A; b1 = {31'd0, busy1A}; b2 = {31'd0, busy2A}; cnt = {26'd0, busyCntA}; end
      1: begin d1 = dout1B; d2 = dout2B; b1 = {31'd0, busy1B}; b2 = {31'd0, busy2B}; cnt = {26'd0, busyCntB}; end
      default: begin d1 = {16'd0, dout1C}; d2 = {16'd0, dout2C}; b1 = {31'd0, busy1C}; b2 = {31'd0, busy2C}; cnt = {28'd0, busyCntC}; end
    endcase
    cmp("dout1", k, d1, expData(k, ard1 & amask(k)));
    cmp("dout2", k, d2, expData(k, ard2 & amask(k)));
    cmp("busy1", k, b1, expBusy(k, ard1 & amask(k)));
    cmp("busy2", k, b2, expBusy(k, ard2 & amask(k)));
    cmp("busyCnt", k, cnt, expCount(k));
  endtask

  // Single compare process: model checks every cycle, then any queued literal checks.
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) checkInst(k);
    end
    while (litQ.size() > 0) begin
      litT t;
      t = litQ.pop_front();
      cmp(t.name, -1, t.act, t.exp);
    end
  end

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    litQ.push_back('{name, act, exp});
  endtask

  task automatic idle();
    rst = 1'b0; wrEn = 1'b0; iss = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    $display("txn t=%0t rst=%0b we=%0b awr=%0d din=%h iss=%0b ia=%0d ard1=%0d ard2=%0d",
             $time, rst, wrEn, awr, din, iss, issAddr, ard1, ard2);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    idle();
    checking = 1'b1;
    ard1 = 5'd5; ard2 = 5'd9;
    @(negedge clk);
    lit("reset dout1", dout1A, 32'd0);
    lit("reset busy1", {31'd0, busy1A}, 32'd0);
    lit("reset cnt", {26'd0, busyCntA}, 32'd0);

    // Write then read
    wrEn = 1'b1; awr = 5'd5; din = 32'hDEADBEEF; ard1 = 5'd0; ard2 = 5'd0;
    tick(); idle(); ard1 = 5'd5; ard2 = 5'd5;
    @(negedge clk);
    lit("wr-rd dout1", dout1A, 32'hDEADBEEF);
    lit("wr-rd dout2", dout2A, 32'hDEADBEEF);
    lit("wr-rd narrow", {16'd0, dout1C}, 32'h0000BEEF);

    // Bypass of a pending register
    iss = 1'b1; issAddr = 5'd7;
    tick(); idle();
    wrEn = 1'b1; awr = 5'd7; din = 32'h12345678; ard2 = 5'd7;
    @(negedge clk);
    lit("bypass dout2", dout2A, 32'h12345678);
    lit("bypass busy2", {31'd0, busy2A}, 32'd0);
    lit("bypass cnt before", {26'd0, busyCntA}, 32'd1);
    tick(); idle();
    @(negedge clk);
    lit("bypass cnt after", {26'd0, busyCntA}, 32'd0);

    // Zero register
    wrEn = 1'b1; awr = 5'd0; din = 32'hFFFFFFFF; iss = 1'b1; issAddr = 5'd0; ard1 = 5'd0;
    tick(); idle();
    @(negedge clk);
    lit("zero dout1", dout1A, 32'd0);
    lit("zero busy1", {31'd0, busy1A}, 32'd0);
    lit("zero cnt", {26'd0, busyCntA}, 32'd0);
    lit("nozero dout1", dout1B, 32'hFFFFFFFF);
    lit("nozero cnt", {26'd0, busyCntB}, 32'd1);

    // Scoreboard sequence
    iss = 1'b1; issAddr = 5'd3; tick();
    issAddr = 5'd4; tick();
    issAddr = 5'd3; tick();
    idle();
    @(negedge clk);
    lit("sb cnt 2", {26'd0, busyCntA}, 32'd2);
    wrEn = 1'b1; awr = 5'd4; din = 32'h44;
    tick(); idle(); ard1 = 5'd4;
    @(negedge clk);
    lit("sb cnt 1", {26'd0, busyCntA}, 32'd1);
    lit("sb busy1 r4", {31'd0, busy1A}, 32'd0);
    iss = 1'b1; issAddr = 5'd3; wrEn = 1'b1; awr = 5'd3; din = 32'h33;
    tick(); idle(); ard1 = 5'd3;
    @(negedge clk);
    lit("sb busy1 r3", {31'd0, busy1A}, 32'd1);
    lit("sb cnt same", {26'd0, busyCntA}, 32'd1);
    lit("sb data r3", dout1A, 32'h33);

    // Fill, reserve, saturate the narrow instance, then reset mid-operation
    for (int a = 1; a < 32; a++) begin
      wrEn = 1'b1; awr = 5'(a); din = 32'h01010101 * a;
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      iss = 1'b1; issAddr = 5'(2 + 3 * i);
      tick();
    end
    idle();
    @(negedge clk);
    lit("fill cnt A", {26'd0, busyCntA}, 32'd10);
    lit("fill cnt C", {28'd0, busyCntC}, 32'd7);
    for (int a = 8; a < 16; a++) begin
      iss = 1'b1; issAddr = 5'(a);
      tick();
    end
    idle();
    @(negedge clk);
    lit("sat cnt C", {28'd0, busyCntC}, 32'd7);
    lit("sat cnt A", {26'd0, busyCntA}, 32'd15);

    rst = 1'b1; wrEn = 1'b1; awr = 5'd9; din = 32'hAAAA5555; iss = 1'b1; issAddr = 5'd9; ard1 = 5'd9;
    tick(); idle();
    @(negedge clk);
    lit("rst cnt A", {26'd0, busyCntA}, 32'd0);
    lit("rst cnt B", {26'd0, busyCntB}, 32'd0);
    lit("rst cnt C", {28'd0, busyCntC}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      ard1 = 5'(a); ard2 = 5'(31 - a);
      @(negedge clk);
      lit("rst dout1", dout1A, 32'd0);
      lit("rst dout2B", dout2B, 32'd0);
      tick();
    end

    // Random traffic checked by the model
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      wrEn    = 1'($urandom_range(0, 1));
      iss     = 1'($urandom_range(0, 1));
      awr     = 5'($urandom_range(0, 31));
      issAddr = (n % 3 == 0) ? awr : 5'($urandom_range(0, 31));
      ard1    = (n % 4 == 0) ? awr : 5'($urandom_range(0, 31));
      ard2    = 5'($urandom_range(0, 31));
      din     = $urandom;
      tick();
    end
    idle();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero and is never busy; when 0, register 0 is an ordinary register.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset; synchronous, active-high.
REQ-006 Ard1  input  ADDR_W  read address, port 1.
REQ-007 Ard2  input  ADDR_W  read address, port 2.
REQ-008 Dout1  output  DATA_W  read data, port 1.
REQ-009 Dout2  output  DATA_W  read data, port 2.
REQ-010 Awr  input  ADDR_W  write address.
REQ-011 Din  input  DATA_W  write data.
REQ-012 WrEn  input  1  write enable; also clears the busy flag of Awr.
REQ-013 Iss  input  1  issue strobe; reserves register IssAddr as pending.
REQ-014 IssAddr  input  ADDR_W  register reserved by Iss.
REQ-015 Busy1  output  1  pending flag of register Ard1.
REQ-016 Busy2  output  1  pending flag of register Ard2.
REQ-017 BusyCnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-018 The block SHALL store 2**ADDR_W registers of DATA_W bits plus one busy flag per register.
REQ-019 Write: at the Clk edge with WrEn=1, reg[Awr] SHALL take Din, except reg 0 when ZERO_REG=1, which SHALL stay 0.
REQ-020 Read: DoutN SHALL be combinational, zero-latency, equal to reg[ArdN]; both ports SHALL be independent and MAY address the same register.
REQ-021 Bypass: when WrEn=1 and Awr==ArdN (and not reg 0 with ZERO_REG=1), DoutN SHALL equal Din in the same cycle.
REQ-022 With ZERO_REG=1, ArdN=0 SHALL always return 0 and BusyN=0, regardless of writes or issues.
REQ-023 Issue: at the Clk edge with Iss=1, busy[IssAddr] SHALL be set (ignored for reg 0 when ZERO_REG=1).
REQ-024 Completion: at the Clk edge with WrEn=1, busy[Awr] SHALL be cleared.
REQ-025 Simultaneous Iss and WrEn on the same address: busy SHALL end set (new reservation wins); data SHALL still be written.
REQ-026 Iss to an already-busy register SHALL leave it busy, with BusyCnt unchanged; WrEn to a non-busy register SHALL write data, with BusyCnt unchanged.
REQ-027 BusyN SHALL equal busy[ArdN] masked to 0 when WrEn=1 and Awr==ArdN in that cycle (write-bypass completes the pending result).
REQ-028 BusyCnt SHALL be a registered count, updated at each edge by +1, -1 or 0 according to REQ-023..026, and SHALL always equal the population count of the busy flags.
REQ-029 BusyCnt SHALL never wrap; its maximum is 2**ADDR_W (2**ADDR_W-1 with ZERO_REG=1).

Reset
REQ-030 At a Clk edge with Rst=1, all registers, all busy flags and BusyCnt SHALL become 0; WrEn and Iss SHALL be ignored in that cycle.
REQ-031 After reset, Dout1=Dout2=0, Busy1=Busy2=0 and BusyCnt=0 SHALL hold until the first write or issue.
REQ-032 Rst asserted mid-operation SHALL discard all pending reservations and data with no residual state.

Verification
REQ-033 Write then read: WrEn=1, Awr=5, Din=0xDEADBEEF; next cycle Ard1=5, Ard2=5 -> Dout1=Dout2=0xDEADBEEF.
REQ-034 Bypass: WrEn=1, Awr=7, Din=0x12345678 and Ard2=7 in the same cycle -> Dout2=0x12345678 before the edge; Busy2=0.
REQ-035 Zero register: ZERO_REG=1, WrEn=1, Awr=0, Din=0xFFFFFFFF; Iss=1, IssAddr=0 -> Dout1 with Ard1=0 reads 0, Busy1=0, BusyCnt=0. Repeat with ZERO_REG=0 -> Dout1 reads 0xFFFFFFFF.
REQ-036 Scoreboard: Iss to 3, 4, 3 on consecutive cycles -> BusyCnt=2; WrEn Awr=4 -> BusyCnt=1, Busy1=0 for Ard1=4; Iss and WrEn both on 3 in the same cycle -> busy[3] stays 1, BusyCnt=1.
REQ-037 Reset mid-operation: registers 1..31 written to nonzero values and 10 registers issued; Rst=1 for one cycle with WrEn=1 and Iss=1 -> all reads 0, BusyCnt=0.
REQ-038 Parameter sweep: DATA_W=16, ADDR_W=3; fill all 8 registers and issue all of them -> BusyCnt=7 (ZERO_REG=1), no wrap; random read/write/issue traffic is checked against a reference model.
